cpu_mem_if: RTL and testbench
=============================

Name: cpu_mem_if

Overview:
- Memory-bus interface stage directly downstream of cpu_control.
- Serves one transaction at a time: instruction fetch, data load or data store, requested by the control FSM during its fetch_io / exec_load_io / exec_store_io phases.
- Converts each request into a held-stable, ack-terminated memory cycle with timeout protection, and returns the result over a valid/ready response channel.
- Latches fetched instruction words into an instruction register for the decode/exec path.

Parameters:
AW, 16, address width
DW, 16, data width
TIMEOUT, 15, max BUS cycles without mem_ack before error (>=1)
TW, 4, timeout counter width; must satisfy 2^TW > TIMEOUT

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  control requests a transaction
req_ready  out  1  interface can accept a request (IDLE)
req_kind  in  2  0=fetch, 1=load, 2=store, 3=reserved
req_addr  in  AW  transaction address
req_wdata  in  DW  store data
rsp_valid  out  1  response available
rsp_ready  in  1  control consumes response
rsp_kind  out  2  kind of completed transaction
rsp_data  out  DW  read data (0 for store/error)
rsp_err  out  1  timeout or reserved kind
ir  out  DW  last successfully fetched instruction
busy  out  1  state != IDLE
mem_en  out  1  bus cycle active
mem_we  out  1  write strobe (store only, qualified by mem_en)
mem_addr  out  AW  bus address
mem_wdata  out  DW  bus write data
mem_rdata  in  DW  bus read data, sampled when mem_ack=1
mem_ack  in  1  bus completes cycle

Behaviour:
- States: IDLE, BUS, RESP. Registered outputs, no combinational path from mem_* inputs to outputs.
- Reset (rst_n=0 at edge): state=IDLE. All outputs 0 except req_ready=1: mem_en, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_kind, rsp_data, rsp_err, ir, busy, timeout counter all 0. Reset mid-transaction aborts it: mem_en drops at that edge, no response is produced, ir is cleared.
- IDLE:
  - req_ready=1.
  - On req_valid, latch kind/addr/wdata.
  - Kind 0..2: go BUS, drive mem_en=1, mem_we=(kind==2), mem_addr, mem_wdata; counter=0.
  - Kind 3: go directly to RESP with rsp_err=1, rsp_data=0; no bus cycle.
- BUS:
  - mem_en/mem_we/mem_addr/mem_wdata held constant for the whole cycle.
  - On mem_ack=1: capture mem_rdata (load/fetch) or 0 (store) into rsp_data; rsp_err=0; go RESP; mem_en/mem_we drop at the same edge.
  - Else if counter==TIMEOUT-1: rsp_err=1, rsp_data=0, go RESP, drop mem_en.
  - Else counter+1.
  - mem_ack and timeout on the same cycle: ack wins (no error).
  - mem_ack outside BUS is ignored.
- RESP:
  - rsp_valid=1 with rsp_kind/rsp_data/rsp_err stable until rsp_ready=1, then IDLE with rsp_valid=0.
  - ir updates to rsp_data on entry to RESP only when kind==0 and err==0; otherwise ir holds.
- Latency: request accepted at edge N, mem_en high from N. If mem_ack is seen at edge N+k (k>=1), rsp_valid is high from N+k. Minimum request-to-response is 1 cycle of bus wait plus 1 response cycle. Back-to-back: rsp_ready at edge M gives IDLE at M; the next request can be accepted at M+1.
- req_valid outside IDLE is ignored (req_ready=0); the requester must hold the request until accepted.
- Only one outstanding transaction. Counter never exceeds TIMEOUT-1.

Test Plan:
- Fetch, addr 0x0010, mem_ack 2 cycles after mem_en with mem_rdata=0xA5C3 -> mem_en high exactly 2 cycles, mem_we=0, rsp_valid with rsp_kind=0, rsp_data=0xA5C3, rsp_err=0, ir=0xA5C3.
- Store addr 0x00FF wdata 0x1234, ack after 1 cycle -> mem_we=1 for that cycle only, mem_wdata=0x1234, rsp_data=0, rsp_err=0, ir unchanged.
- Load with no mem_ack, TIMEOUT=15 -> mem_en high exactly 15 cycles, then rsp_err=1, rsp_data=0. Separately, ack asserted on cycle 15 -> rsp_err=0 with the read data.
- req_kind=3 -> no mem_en pulse, rsp_valid next cycle with rsp_err=1. Failed fetch (timeout) leaves the prior ir=0xA5C3.
- Hold rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0, new req_valid ignored. After rsp_ready, the next request is accepted on the following edge.
- Assert rst_n=0 mid-BUS -> at that edge mem_en=0, ir=0, state IDLE, req_ready=1, no rsp_valid afterwards; a subsequent fetch completes normally.

Source files
------------

// File: rtl/cpu_mem_if_if.sv
// Request/response channel and memory-bus signals of cpu_mem_if.
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1; the sender holds valid and its payload stable until then, and
// the receiver never makes ready depend combinationally on valid.
interface cpu_mem_if_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_kind;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_kind;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic [DW-1:0] ir;
    logic          busy;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    // The requester plus the memory model drive this side.
    modport master (
        output req_valid, req_kind, req_addr, req_wdata, rsp_ready,
               mem_rdata, mem_ack,
        input  req_ready, rsp_valid, rsp_kind, rsp_data, rsp_err, ir, busy,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    // The interface stage itself.
    modport slave (
        input  req_valid, req_kind, req_addr, req_wdata, rsp_ready,
               mem_rdata, mem_ack,
        output req_ready, rsp_valid, rsp_kind, rsp_data, rsp_err, ir, busy,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cpu_mem_if.sv
// Memory-bus interface stage: turns one fetch/load/store request into a
// held-stable, ack-terminated bus cycle with timeout, returns the result on
// a valid/ready response channel and keeps the last fetched instruction.
module cpu_mem_if #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 15,
    parameter int TW      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    cpu_mem_if_if.slave bus,
    output logic [1:0]  o_state_dbg
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0]    KIND_FETCH = 2'd0;
    localparam logic [1:0]    KIND_STORE = 2'd2;
    localparam logic [1:0]    KIND_RSV   = 2'd3;
    localparam logic [TW-1:0] CNT_LAST   = TW'(TIMEOUT - 1);

    state_t        r_state,    w_state_nxt;
    logic [1:0]    r_kind,     w_kind_nxt;
    logic [AW-1:0] r_addr,     w_addr_nxt;
    logic [DW-1:0] r_wdata,    w_wdata_nxt;
    logic          r_mem_en,   w_mem_en_nxt;
    logic          r_mem_we,   w_mem_we_nxt;
    logic [TW-1:0] r_cnt,      w_cnt_nxt;
    logic [DW-1:0] r_rsp_data, w_rsp_data_nxt;
    logic          r_rsp_err,  w_rsp_err_nxt;
    logic [DW-1:0] r_ir,       w_ir_nxt;

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_kind     <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_cnt      <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_ir       <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_kind     <= w_kind_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_mem_en   <= w_mem_en_nxt;
            r_mem_we   <= w_mem_we_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rsp_data <= w_rsp_data_nxt;
            r_rsp_err  <= w_rsp_err_nxt;
            r_ir       <= w_ir_nxt;
        end
    end

    // Next-state and next-register values; every register holds by default.
    always_comb begin
        w_state_nxt    = r_state;
        w_kind_nxt     = r_kind;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_mem_en_nxt   = r_mem_en;
        w_mem_we_nxt   = r_mem_we;
        w_cnt_nxt      = r_cnt;
        w_rsp_data_nxt = r_rsp_data;
        w_rsp_err_nxt  = r_rsp_err;
        w_ir_nxt       = r_ir;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_kind_nxt  = bus.req_kind;
                    w_addr_nxt  = bus.req_addr;
                    w_wdata_nxt = bus.req_wdata;
                    w_cnt_nxt   = '0;
                    if (bus.req_kind == KIND_RSV) begin
                        // Reserved kind is answered with an error, no bus cycle.
                        w_state_nxt    = ST_RESP;
                        w_rsp_err_nxt  = 1'b1;
                        w_rsp_data_nxt = '0;
                    end else begin
                        w_state_nxt  = ST_BUS;
                        w_mem_en_nxt = 1'b1;
                        w_mem_we_nxt = (bus.req_kind == KIND_STORE);
                    end
                end
            end
            ST_BUS: begin
                // Ack is checked first so an ack on the last allowed cycle wins.
                if (bus.mem_ack) begin
                    w_state_nxt    = ST_RESP;
                    w_mem_en_nxt   = 1'b0;
                    w_mem_we_nxt   = 1'b0;
                    w_rsp_err_nxt  = 1'b0;
                    w_rsp_data_nxt = (r_kind == KIND_STORE) ? '0 : bus.mem_rdata;
                    if (r_kind == KIND_FETCH) begin
                        w_ir_nxt = bus.mem_rdata;
                    end
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt    = ST_RESP;
                    w_mem_en_nxt   = 1'b0;
                    w_mem_we_nxt   = 1'b0;
                    w_rsp_err_nxt  = 1'b1;
                    w_rsp_data_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + TW'(1);
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // All outputs come from registers or decode of the state register.
    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.rsp_valid = (r_state == ST_RESP);
    assign bus.rsp_kind  = r_kind;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.ir        = r_ir;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign o_state_dbg   = r_state;
endmodule

// File: tb/tb_cpu_mem_if.sv
// Directed bench for cpu_mem_if: a table of transactions with hand-computed
// results, plus hand-written sequences for reset, response back-pressure
// and back-to-back acceptance.
module tb_cpu_mem_if;
    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg;
    int         n_cmp;
    int         n_err;

    cpu_mem_if_if #(.AW(16), .DW(16)) bus ();

    cpu_mem_if #(.AW(16), .DW(16), .TIMEOUT(15), .TW(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .o_state_dbg (state_dbg)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  kind;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          ack_at;    // cycle of mem_en on which ack arrives, 0 = never
        logic [15:0] rdata;
        int          exp_en;    // cycles mem_en stays high
        logic        exp_we;
        logic [15:0] exp_data;
        logic        exp_err;
        logic [15:0] exp_ir;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req_valid = 1'b0;
        bus.req_kind  = 2'd0;
        bus.req_addr  = 16'h0;
        bus.req_wdata = 16'h0;
        bus.rsp_ready = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0;
    endtask

    // Drive one transaction through accept, bus cycle and response.
    task automatic run_txn(input vec_t v);
        int en_cnt;
        bus.req_valid = 1'b1;
        bus.req_kind  = v.kind;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        step();
        bus.req_valid = 1'b0;
        en_cnt = 0;
        for (int c = 1; c <= 40 && bus.mem_en; c++) begin
            en_cnt++;
            chk("mem_we", bus.mem_we, v.exp_we);
            chk("mem_addr", bus.mem_addr, v.addr);
            chk("mem_wdata", bus.mem_wdata, v.wdata);
            bus.mem_ack   = (c == v.ack_at);
            bus.mem_rdata = (c == v.ack_at) ? v.rdata : 16'($urandom_range(0, 16'hFFFF));
            step();
            bus.mem_ack = 1'b0;
        end
        chk("mem_en_cycles", en_cnt, v.exp_en);
        chk("rsp_valid", bus.rsp_valid, 1'b1);
        chk("rsp_kind", bus.rsp_kind, v.kind);
        chk("rsp_data", bus.rsp_data, v.exp_data);
        chk("rsp_err", bus.rsp_err, v.exp_err);
        chk("ir", bus.ir, v.exp_ir);
        chk("busy", bus.busy, 1'b1);
        chk("mem_we_after", bus.mem_we, 1'b0);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_drop", bus.rsp_valid, 1'b0);
        chk("req_ready_back", bus.req_ready, 1'b1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        idle_inputs();
        //           kind   addr      wdata     ack rdata     en we data      err   ir
        vecs[0] = '{2'd0, 16'h0010, 16'h0000, 2,  16'hA5C3, 2,  0, 16'hA5C3, 1'b0, 16'hA5C3};
        vecs[1] = '{2'd2, 16'h00FF, 16'h1234, 1,  16'hDEAD, 1,  1, 16'h0000, 1'b0, 16'hA5C3};
        vecs[2] = '{2'd1, 16'h0200, 16'h0000, 0,  16'h0000, 15, 0, 16'h0000, 1'b1, 16'hA5C3};
        vecs[3] = '{2'd1, 16'h0300, 16'h0000, 15, 16'h5A5A, 15, 0, 16'h5A5A, 1'b0, 16'hA5C3};
        vecs[4] = '{2'd3, 16'h0400, 16'h9999, 0,  16'h0000, 0,  0, 16'h0000, 1'b1, 16'hA5C3};
        vecs[5] = '{2'd0, 16'h0011, 16'h0000, 0,  16'h0000, 15, 0, 16'h0000, 1'b1, 16'hA5C3};
        vecs[6] = '{2'd0, 16'h0012, 16'h0000, 1,  16'h1357, 1,  0, 16'h1357, 1'b0, 16'h1357};
        vecs[7] = '{2'd1, 16'h0013, 16'h0000, 3,  16'hBEEF, 3,  0, 16'hBEEF, 1'b0, 16'h1357};

        // Reset state.
        rst_n = 1'b0;
        step();
        step();
        chk("rst_req_ready", bus.req_ready, 1'b1);
        chk("rst_mem_en", bus.mem_en, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_ir", bus.ir, 16'h0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 16'h0);
        chk("rst_state", state_dbg, 2'd0);
        rst_n = 1'b1;
        step();

        // Ack while idle is ignored.
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h7777;
        step();
        bus.mem_ack = 1'b0;
        chk("idle_ack_rsp_valid", bus.rsp_valid, 1'b0);
        chk("idle_ack_ir", bus.ir, 16'h0);

        // Table of transactions.
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i]);
        end

        // Response back-pressure for 5 cycles with a competing request.
        bus.req_valid = 1'b1;
        bus.req_kind  = 2'd1;
        bus.req_addr  = 16'h0500;
        step();
        bus.req_kind  = 2'd0;
        bus.req_addr  = 16'h0600;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h2468;
        step();
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("hold_rsp_valid", bus.rsp_valid, 1'b1);
            chk("hold_rsp_data", bus.rsp_data, 16'h2468);
            chk("hold_rsp_kind", bus.rsp_kind, 2'd1);
            chk("hold_req_ready", bus.req_ready, 1'b0);
            chk("hold_mem_en", bus.mem_en, 1'b0);
            step();
        end
        // Release at edge M: back in IDLE, request not yet taken.
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        chk("b2b_idle_ready", bus.req_ready, 1'b1);
        chk("b2b_idle_mem_en", bus.mem_en, 1'b0);
        chk("b2b_idle_rsp_valid", bus.rsp_valid, 1'b0);
        // Edge M+1: the held request is accepted.
        step();
        bus.req_valid = 1'b0;
        chk("b2b_mem_en", bus.mem_en, 1'b1);
        chk("b2b_mem_addr", bus.mem_addr, 16'h0600);
        chk("b2b_state", state_dbg, 2'd1);

        // Reset in the middle of that bus cycle.
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_mem_en", bus.mem_en, 1'b0);
        chk("midrst_ir", bus.ir, 16'h0);
        chk("midrst_req_ready", bus.req_ready, 1'b1);
        chk("midrst_state", state_dbg, 2'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h4444;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("midrst_no_rsp", bus.rsp_valid, 1'b0);
        end
        bus.mem_ack = 1'b0;
        run_txn('{2'd0, 16'h0020, 16'h0000, 2, 16'hC0DE, 2, 0, 16'hC0DE, 1'b0, 16'hC0DE});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
